// File: rtl/uart_msg_sequencer.sv
// Walks the message ROM from address 0 to MSG_LEN-1 and streams each byte over valid/ready.
// Optional NUL-terminated messages: define UART_MSG_SEQ_NUL_TERM_EN.
//
// state | meaning
// IDLE  | waiting for start_i
// ADDR  | ROM samples rom_addr_o
// LATCH | registered ROM byte captured into tx_data_o
// SEND  | byte presented, waiting for handshake
// DONE  | one-cycle done_o pulse
module uart_msg_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int MSG_LEN    = 512,
  parameter bit REPEAT     = 1'b0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [7:0]            rom_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MSG_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(MSG_LEN);

  typedef enum logic [2:0] {IDLE, ADDR, LATCH, SEND, DONE} state_t;

  state_t state, state_nxt;
  logic   handshake;
  logic   last_addr;
  logic   nul_byte;

  assign handshake = (state == SEND) && tx_valid_o && tx_ready_i;
  assign last_addr = (rom_addr_o == LAST_ADDR);

`ifdef UART_MSG_SEQ_NUL_TERM_EN
  assign nul_byte = (rom_data_i == 8'h00);
`else
  assign nul_byte = 1'b0;
`endif

  assign busy_o = (state == ADDR) || (state == LATCH) || (state == SEND);
  assign done_o = (state == DONE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = ADDR;
      ADDR:  state_nxt = LATCH;
      LATCH: begin
        if (nul_byte) state_nxt = REPEAT ? ADDR : DONE;
        else          state_nxt = SEND;
      end
      SEND: begin
        if (handshake) state_nxt = (last_addr && !REPEAT) ? DONE : ADDR;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_o <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      count_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            rom_addr_o <= '0;
            count_o    <= '0;
          end
        end
        LATCH: begin
          // A NUL ends the message without presenting or counting it
          if (nul_byte) begin
            if (REPEAT) rom_addr_o <= '0;
          end else begin
            tx_data_o  <= rom_data_i;
            tx_valid_o <= 1'b1;
          end
        end
        SEND: begin
          if (handshake) begin
            tx_valid_o <= 1'b0;
            if (REPEAT || (count_o != COUNT_MAX)) count_o <= count_o + 1'b1;
            if (!last_addr)  rom_addr_o <= rom_addr_o + 1'b1;
            else if (REPEAT) rom_addr_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: a non-repeating 4-byte instance and a repeating 3-byte instance
// checked every cycle against a message-position model, plus directed literal checks.
module tb_uart_msg_sequencer;

`ifdef UART_MSG_SEQ_NUL_TERM_EN
  localparam bit NUL_EN = 1'b1;
`else
  localparam bit NUL_EN = 1'b0;
`endif

  logic clock, rst_n, start, ready;
  logic [2:0] addr0;
  logic [7:0] rdata0, data0;
  logic       valid0, busy0, done0;
  logic [3:0] cnt0;
  logic [1:0] addr1;
  logic [7:0] rdata1, data1;
  logic       valid1, busy1, done1;
  logic [2:0] cnt1;

  logic [7:0] rom [2][8];

  int checks = 0;
  int errors = 0;

  uart_msg_sequencer #(.ADDR_WIDTH(3), .MSG_LEN(4), .REPEAT(1'b0)) dut0 (
    .clock(clock), .rst_n(rst_n), .start_i(start), .rom_addr_o(addr0), .rom_data_i(rdata0),
    .tx_data_o(data0), .tx_valid_o(valid0), .tx_ready_i(ready), .busy_o(busy0),
    .done_o(done0), .count_o(cnt0));

  uart_msg_sequencer #(.ADDR_WIDTH(2), .MSG_LEN(3), .REPEAT(1'b1)) dut1 (
    .clock(clock), .rst_n(rst_n), .start_i(start), .rom_addr_o(addr1), .rom_data_i(rdata1),
    .tx_data_o(data1), .tx_valid_o(valid1), .tx_ready_i(ready), .busy_o(busy1),
    .done_o(done1), .count_o(cnt1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered ROMs: data appears one cycle after the address is sampled
  always @(posedge clock) begin
    rdata0 <= rom[0][addr0];
    rdata1 <= rom[1][addr1];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: message position, gap to next presentation, pending byte, count
  int         mlen [2] = '{4, 3};
  bit         rep  [2] = '{1'b0, 1'b1};
  int         cmod [2] = '{16, 8};
  int         m_pos [2], m_wait [2], m_cnt [2], m_addr [2];
  bit         m_active [2], m_valid [2], m_done [2];
  logic [7:0] m_data [2];
  logic [7:0] m_b;

  function automatic void end_msg(int d);
    if (rep[d]) begin
      m_pos[d]  = 0;
      m_addr[d] = 0;
      m_wait[d] = 2;
    end else begin
      m_active[d] = 1'b0;
      m_done[d]   = 1'b1;
    end
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_pos[d] = 0; m_wait[d] = 0; m_cnt[d] = 0; m_addr[d] = 0;
        m_active[d] = 1'b0; m_valid[d] = 1'b0; m_done[d] = 1'b0; m_data[d] = 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_done[d]) begin
          m_done[d] = 1'b0;
        end else if (!m_active[d]) begin
          if (start) begin
            m_active[d] = 1'b1;
            m_pos[d] = 0; m_addr[d] = 0; m_cnt[d] = 0; m_wait[d] = 2;
          end
        end else if (!m_valid[d]) begin
          m_wait[d]--;
          if (m_wait[d] == 0) begin
            m_b = rom[d][m_pos[d]];
            if (NUL_EN && m_b == 8'h00) end_msg(d);
            else begin
              m_valid[d] = 1'b1;
              m_data[d]  = m_b;
            end
          end
        end else if (ready) begin
          m_valid[d] = 1'b0;
          m_cnt[d]   = (m_cnt[d] + 1) % cmod[d];
          if (m_pos[d] == mlen[d] - 1) end_msg(d);
          else begin
            m_pos[d]++;
            m_addr[d] = m_pos[d];
            m_wait[d] = 2;
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en) begin
      chk("d0_valid", valid0, m_valid[0]);
      chk("d0_data",  data0,  m_data[0]);
      chk("d0_addr",  addr0,  m_addr[0]);
      chk("d0_count", cnt0,   m_cnt[0]);
      chk("d0_busy",  busy0,  m_active[0]);
      chk("d0_done",  done0,  m_done[0]);
      chk("d1_valid", valid1, m_valid[1]);
      chk("d1_data",  data1,  m_data[1]);
      chk("d1_addr",  addr1,  m_addr[1]);
      chk("d1_count", cnt1,   m_cnt[1]);
      chk("d1_busy",  busy1,  m_active[1]);
      chk("d1_done",  done1,  m_done[1]);
    end
  end

  // Directed-test recorder for dut0, cycle numbers relative to the start cycle t0
  bit         rec_en = 1'b0;
  int         t0 = 0;
  int         done_cyc = -1;
  int         done1_cnt = 0;
  int         hs_cyc [$];
  logic [7:0] hs_dat [$];
  always @(negedge clock) begin
    if (done1) done1_cnt++;
    if (rec_en) begin
      if (valid0 && ready) begin
        hs_cyc.push_back(cyc - t0);
        hs_dat.push_back(data0);
      end
      if (done0) done_cyc = cyc - t0;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic start_rec();
    hs_cyc.delete();
    hs_dat.delete();
    done_cyc = -1;
    start = 1'b1;
    t0 = cyc;
    rec_en = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] msg_rom [4] = '{8'h41, 8'h42, 8'h43, 8'h0A};
  logic [7:0] nul_rom [4] = '{8'h48, 8'h49, 8'h00, 8'h5A};
  int exp_n;
  int n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) rom[d][i] = 8'h00;

    // Reset then idle
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("reset_idle_addr", addr0, 0);
    chk("reset_idle_valid", valid0, 0);
    chk("reset_idle_count", cnt0, 0);
    chk("reset_idle_busy", {busy0, done0, busy1, done1}, 0);

    // Single message with ready high; extra starts while busy and in DONE are ignored
    for (int i = 0; i < 4; i++) begin
      rom[0][i] = msg_rom[i];
      rom[1][i] = msg_rom[i];
    end
    ready = 1'b1;
    start_rec();
    for (int k = 1; k <= 20; k++) begin
      step();
      start = (k == 5 || k == 13);
    end
    rec_en = 1'b0;
    chk("single_nbytes", hs_cyc.size(), 4);
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++) begin
      chk("single_cycle", hs_cyc[i], 3 + 3 * i);
      chk("single_byte", hs_dat[i], msg_rom[i]);
    end
    chk("single_done_cycle", done_cyc, 13);
    chk("single_count", cnt0, 4);
    chk("single_idle_after", busy0, 0);

    // Backpressure on byte 42
    start = 1'b1;
    step();
    start = 1'b0;
    for (n = 0; n < 20 && !(valid0 && data0 == 8'h42); n++) step();
    chk("bp_reach_42", n < 20, 1);
    ready = 1'b0;
    repeat (5) step();
    chk("bp_hold_valid", valid0, 1);
    chk("bp_hold_data", data0, 8'h42);
    ready = 1'b1;
    t0 = cyc;
    step();
    for (n = 0; n < 20 && !(valid0 && data0 == 8'h43); n++) step();
    chk("bp_next_latency", cyc - t0, 3);
    repeat (15) step();

    // Reset mid-message during SEND of byte 2
    start = 1'b1;
    step();
    start = 1'b0;
    for (n = 0; n < 20 && !(valid0 && data0 == 8'h42); n++) step();
    chk("mid_reach_42", n < 20, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", {valid0, valid1}, 0);
    chk("mid_reset_busy", {busy0, busy1}, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("mid_wait_idle", busy0, 0);
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    for (n = 0; n < 20 && !valid0; n++) step();
    chk("mid_restart_byte", data0, 8'h41);
    chk("mid_restart_latency", cyc - t0, 3);
    repeat (15) step();
    chk("repeat_never_done", done1_cnt, 0);

    // Randomized rounds: random ROM (with zeros), ready and start
    for (int r = 0; r < 4; r++) begin
      pulse_reset();
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 8; i++)
          rom[d][i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int k = 0; k < 800; k++) begin
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 15) == 0);
        step();
      end
      start = 1'b0;
    end

    // NUL in the message: terminates only when the feature is built in
    pulse_reset();
    for (int i = 0; i < 4; i++) rom[0][i] = nul_rom[i];
    ready = 1'b1;
    start_rec();
    step();
    start = 1'b0;
    repeat (25) step();
    rec_en = 1'b0;
    exp_n = NUL_EN ? 2 : 4;
    chk("nul_nbytes", hs_dat.size(), exp_n);
    for (int i = 0; i < 4 && i < hs_dat.size(); i++) chk("nul_byte", hs_dat[i], nul_rom[i]);
    chk("nul_done_seen", done_cyc >= 0, 1);
    chk("nul_count", cnt0, exp_n);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_msg_sequencer.md
Name: uart_msg_sequencer

Overview:
- Sits directly upstream of the hex-file message ROM in the UART example. It drives the ROM read address and consumes the registered ROM output byte.
- Presents each byte to the UART transmitter over a valid/ready stream.
- Walks the message from address 0 to MSG_LEN-1 once per start pulse. Optionally loops.

Parameters:
- ADDR_WIDTH, 10, width of ROM address; must satisfy 2**ADDR_WIDTH >= MSG_LEN
- MSG_LEN, 512, number of bytes in the message (1..2**ADDR_WIDTH)
- REPEAT, 0, 1 = restart at address 0 after last byte instead of stopping

Ports:
- clock  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins transmission when idle
- rom_addr_o  out  ADDR_WIDTH  read address to ROM (registered)
- rom_data_i  in  8  ROM output; valid one cycle after the ROM samples rom_addr_o
- tx_data_o  out  8  byte to transmitter
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  transmitter accepts byte when tx_valid_o && tx_ready_i
- busy_o  out  1  high in any state except IDLE/DONE
- done_o  out  1  one-cycle pulse after last byte accepted (non-REPEAT)
- count_o  out  ADDR_WIDTH+1  bytes accepted since last start

Behaviour:
- Reset (async assert, sync release): state=IDLE; rom_addr_o=0; tx_data_o=0; tx_valid_o=0; busy_o=0; done_o=0; count_o=0.
- States: IDLE, ADDR, LATCH, SEND, DONE.
- IDLE: start_i=1 -> rom_addr_o<=0, count_o<=0, state ADDR. Otherwise hold.
- ADDR: one cycle while ROM samples rom_addr_o. Unconditionally go to LATCH.
- LATCH: tx_data_o<=rom_data_i, tx_valid_o<=1, state SEND.
- SEND: tx_data_o and tx_valid_o held stable until handshake. On tx_valid_o && tx_ready_i:
  - tx_valid_o<=0 and count_o<=count_o+1.
  - If rom_addr_o==MSG_LEN-1: with REPEAT=1, rom_addr_o<=0 and state ADDR; with REPEAT=0, state DONE.
  - Otherwise rom_addr_o<=rom_addr_o+1 and state ADDR.
- DONE: done_o=1 for exactly one cycle, then IDLE. rom_addr_o keeps the last address.
- Latency: start_i at cycle 0 -> first tx_valid_o at cycle 3. Minimum 3 cycles per byte when tx_ready_i is held high.
- start_i outside IDLE is ignored, including in DONE.
- tx_ready_i high while tx_valid_o=0 has no effect.
- tx_valid_o never deasserts without a handshake, except on reset.
- Address arithmetic is unsigned modulo 2**ADDR_WIDTH. count_o saturates at MSG_LEN (REPEAT=0). With REPEAT=1, count_o wraps modulo 2**(ADDR_WIDTH+1).
- MSG_LEN=1: one byte at address 0, then DONE (or repeats address 0).
- Reset asserted mid-message: all outputs return to reset values immediately and no partial handshake completes. After release the block waits in IDLE for start_i.

Optional Feature:
- Macro: UART_MSG_SEQ_NUL_TERM_EN.
- Defined: in LATCH, if rom_data_i==8'h00, no byte is presented (tx_valid_o stays 0). The message ends early:
  - REPEAT=0: go to DONE and pulse done_o.
  - REPEAT=1: rom_addr_o<=0, state ADDR.
  - The NUL byte is not counted. Reaching MSG_LEN-1 still terminates as normal.
- Not defined: 8'h00 is an ordinary data byte and is transmitted.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release, no start -> all outputs 0, rom_addr_o=0 for 20 cycles.
- Single message, ready always high: MSG_LEN=4, ROM={41,42,43,0A}, pulse start_i at cycle 0 -> tx_valid_o at cycles 3,6,9,12 with bytes 41,42,43,0A; done_o pulses at cycle 13; count_o=4.
- Backpressure: tx_ready_i low for 5 cycles while byte 42 is valid -> tx_data_o holds 42 and tx_valid_o stays 1; after ready, the next byte follows 3 cycles later; no byte lost or duplicated.
- Ignored start and REPEAT: start_i pulsed while busy -> no restart. With REPEAT=1, MSG_LEN=3 -> stream 41,42,43,41,42,... and done_o never pulses.
- Reset mid-message: assert rst_n during SEND of byte 2 -> tx_valid_o=0 same cycle. After release and a new start_i, the stream restarts at address 0 with byte 41.
- NUL termination (macro defined): ROM={48,49,00,5A}, MSG_LEN=4 -> only 48,49 are sent; done_o pulses; count_o=2. Without the macro, 48,49,00,5A are all sent.
